vic_video_out: RTL and testbench

Output stage of the VIC-II video path, directly downstream of the sync generator and pixel source. Each clock it takes a 4-bit VIC colour index with the raster position and sync signals, and maps the index through a 16-entry programmable palette to 12-bit RGB. It aligns hsync and vsync to the pipelined colour, forces blanking outside the display window, and provides built-in test patterns and a frame counter for bring-up.

---
 rtl/vic_video_out_pkg.sv | 60 ++++++
 rtl/vic_video_out_palette_ram.sv | 32 +++
 rtl/vic_video_out.sv | 112 +++++++++++
 tb/tb_vic_video_out.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vic_video_out_pkg.sv
// rtl/vic_video_out_pkg.sv - shared constants for the VIC-II video output stage
// Contents:
//   VIC_COLOR_W             width of a VIC colour index
//   vic_mode_e              source-select encodings for i_mode
//   VIC_PAL_0..VIC_PAL_15   power-on palette, {R,G,B} nibbles
//   vic_pal_default()       index -> default palette entry
package vic_video_out_pkg;

  localparam int VIC_COLOR_W = 4;
  localparam int VIC_RGB_W   = 12;
  localparam int VIC_PAL_N   = 16;

  typedef enum logic [1:0] {
    VIC_MODE_PIXEL = 2'd0,
    VIC_MODE_BARS  = 2'd1,
    VIC_MODE_GRAD  = 2'd2,
    VIC_MODE_CHECK = 2'd3
  } vic_mode_e;

  localparam logic [VIC_RGB_W-1:0] VIC_PAL_0  = 12'h000;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_1  = 12'hFFF;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_2  = 12'h833;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_3  = 12'h6BB;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_4  = 12'h839;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_5  = 12'h5A4;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_6  = 12'h438;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_7  = 12'hBC7;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_8  = 12'h852;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_9  = 12'h540;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_10 = 12'hB66;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_11 = 12'h555;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_12 = 12'h777;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_13 = 12'h9E8;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_14 = 12'h76C;
  localparam logic [VIC_RGB_W-1:0] VIC_PAL_15 = 12'h999;

  function automatic logic [VIC_RGB_W-1:0] vic_pal_default(input logic [VIC_COLOR_W-1:0] idx);
    logic [VIC_RGB_W-1:0] rgb;
    case (idx)
      4'd0:    rgb = VIC_PAL_0;
      4'd1:    rgb = VIC_PAL_1;
      4'd2:    rgb = VIC_PAL_2;
      4'd3:    rgb = VIC_PAL_3;
      4'd4:    rgb = VIC_PAL_4;
      4'd5:    rgb = VIC_PAL_5;
      4'd6:    rgb = VIC_PAL_6;
      4'd7:    rgb = VIC_PAL_7;
      4'd8:    rgb = VIC_PAL_8;
      4'd9:    rgb = VIC_PAL_9;
      4'd10:   rgb = VIC_PAL_10;
      4'd11:   rgb = VIC_PAL_11;
      4'd12:   rgb = VIC_PAL_12;
      4'd13:   rgb = VIC_PAL_13;
      4'd14:   rgb = VIC_PAL_14;
      default: rgb = VIC_PAL_15;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vic_video_out_palette_ram.sv
// rtl/vic_video_out_palette_ram.sv - 16 x 12-bit programmable palette (vic_palette_ram)
// Ports:
//   clk, reset        pixel clock, async active-high reset (restores defaults)
//   we, waddr, wdata  synchronous write port
//   raddr, rdata      combinational read port; a same-edge write is not yet visible
module vic_palette_ram
  import vic_video_out_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [VIC_COLOR_W-1:0] waddr,
  input  logic [VIC_RGB_W-1:0]   wdata,
  input  logic [VIC_COLOR_W-1:0] raddr,
  output logic [VIC_RGB_W-1:0]   rdata
);

  logic [VIC_RGB_W-1:0] mem [VIC_PAL_N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VIC_PAL_N; i++) begin
        mem[i] <= vic_pal_default(VIC_COLOR_W'(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vic_video_out.sv
// rtl/vic_video_out.sv - VIC-II output stage: source select, palette lookup, blanking, sync align
// Ports:
//   clk, reset                      pixel clock, async active-high reset
//   i_hsync, i_vsync, i_display_on  raster timing from the sync generator
//   i_hpos, i_vpos                  raster position (POS_W bits, POS_W >= 10)
//   i_color, i_mode                 pixel index and source select
//   i_pal_we, i_pal_addr, i_pal_data palette write port
//   o_hsync, o_vsync                syncs delayed 2 clocks to match RGB
//   o_red, o_green, o_blue          palette colour, zero outside the display window
//   o_frame                         count of vsync rising edges, wraps at 256
module vic_video_out
  import vic_video_out_pkg::*;
#(
  parameter int POS_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_display_on,
  input  logic [POS_W-1:0]       i_hpos,
  input  logic [POS_W-1:0]       i_vpos,
  input  logic [VIC_COLOR_W-1:0] i_color,
  input  logic [1:0]             i_mode,
  input  logic                   i_pal_we,
  input  logic [VIC_COLOR_W-1:0] i_pal_addr,
  input  logic [VIC_RGB_W-1:0]   i_pal_data,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [3:0]             o_red,
  output logic [3:0]             o_green,
  output logic [3:0]             o_blue,
  output logic [7:0]             o_frame
);

  logic [VIC_COLOR_W-1:0] index_next;
  logic [VIC_COLOR_W-1:0] index_s1;
  logic                   display_on_s1;
  logic                   hsync_s1;
  logic                   vsync_s1;
  logic                   vsync_q;
  logic [VIC_RGB_W-1:0]   pal_rdata;

  // Only a few position bits feed the test patterns; the rest are intentionally ignored.
  logic unused_pos;
  assign unused_pos = ^{i_hpos, i_vpos};

  // Pattern indices are plain bit selects, so they wrap naturally with no saturation.
  always_comb begin
    index_next = i_color;
    case (vic_mode_e'(i_mode))
      VIC_MODE_PIXEL: index_next = i_color;
      VIC_MODE_BARS:  index_next = i_hpos[9:6];
      VIC_MODE_GRAD:  index_next = i_vpos[3:0];
      VIC_MODE_CHECK: index_next = {i_hpos[4] ^ i_vpos[4], 3'b000};
      default:        index_next = i_color;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_s1      <= '0;
      display_on_s1 <= 1'b0;
      hsync_s1      <= 1'b0;
      vsync_s1      <= 1'b0;
    end else begin
      index_s1      <= index_next;
      display_on_s1 <= i_display_on;
      hsync_s1      <= i_hsync;
      vsync_s1      <= i_vsync;
    end
  end

  vic_palette_ram u_palette (
    .clk   (clk),
    .reset (reset),
    .we    (i_pal_we),
    .waddr (i_pal_addr),
    .wdata (i_pal_data),
    .raddr (index_s1),
    .rdata (pal_rdata)
  );

  // The palette read here sees the pre-write contents when a write lands on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
    end else begin
      {o_red, o_green, o_blue} <= display_on_s1 ? pal_rdata : '0;
      o_hsync <= hsync_s1;
      o_vsync <= vsync_s1;
    end
  end

  // Edge register resets low so a vsync already high at release still counts once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b0;
      o_frame <= '0;
    end else begin
      vsync_q <= i_vsync;
      if (i_vsync && !vsync_q) begin
        o_frame <= o_frame + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vic_video_out.sv
// tb/tb_vic_video_out.sv - scoreboard testbench for vic_video_out
module tb_vic_video_out;

  localparam logic [11:0] PAL_DEF [16] = '{
    12'h000, 12'hFFF, 12'h833, 12'h6BB, 12'h839, 12'h5A4, 12'h438, 12'hBC7,
    12'h852, 12'h540, 12'hB66, 12'h555, 12'h777, 12'h9E8, 12'h76C, 12'h999
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_hsync = 1'b0, i_vsync = 1'b0, i_display_on = 1'b0;
  logic [9:0]  i_hpos = '0, i_vpos = '0;
  logic [3:0]  i_color = '0;
  logic [1:0]  i_mode = '0;
  logic        i_pal_we = 1'b0;
  logic [3:0]  i_pal_addr = '0;
  logic [11:0] i_pal_data = '0;
  logic        o_hsync, o_vsync;
  logic [3:0]  o_red, o_green, o_blue;
  logic [7:0]  o_frame;

  vic_video_out #(.POS_W(10)) dut (
    .clk(clk), .reset(reset),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_display_on(i_display_on),
    .i_hpos(i_hpos), .i_vpos(i_vpos), .i_color(i_color), .i_mode(i_mode),
    .i_pal_we(i_pal_we), .i_pal_addr(i_pal_addr), .i_pal_data(i_pal_data),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int due; logic [11:0] rgb; logic hs; logic vs; } px_t;
  typedef struct { int due; logic [7:0] frame; } fr_t;
  px_t sb[$];
  fr_t fq[$];

  int n_checks = 0;
  int n_fail = 0;

  logic [11:0] pal_m [16];
  logic [7:0]  frame_m;
  logic        prev_vs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every expectation whose output edge has just passed.
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        px_t e;
        e = sb.pop_front();
        if (e.due < cyc) check("rgb_missed_slot", 32'(e.due), 32'(cyc));
        else begin
          check("rgb", {o_red, o_green, o_blue}, e.rgb);
          check("sync", {o_hsync, o_vsync}, {e.hs, e.vs});
        end
      end
      while (fq.size() > 0 && fq[0].due <= cyc) begin
        fr_t f;
        f = fq.pop_front();
        check("frame", o_frame, f.frame);
      end
    end
  end

  // Drive one pixel; the write (if any) commits one edge before this pixel's palette read.
  task automatic pix(input logic [1:0] mode, input logic [3:0] color, input logic [9:0] hp,
                     input logic [9:0] vp, input logic disp, input logic hs, input logic vs,
                     input logic we = 1'b0, input logic [3:0] wa = 4'd0,
                     input logic [11:0] wd = 12'h000);
    logic [3:0] idx;
    i_mode = mode; i_color = color; i_hpos = hp; i_vpos = vp;
    i_display_on = disp; i_hsync = hs; i_vsync = vs;
    i_pal_we = we; i_pal_addr = wa; i_pal_data = wd;
    if (we) pal_m[wa] = wd;
    case (mode)
      2'd0: idx = color;
      2'd1: idx = hp[9:6];
      2'd2: idx = vp[3:0];
      default: idx = {hp[4] ^ vp[4], 3'b000};
    endcase
    sb.push_back('{cyc + 2, disp ? pal_m[idx] : 12'h000, hs, vs});
    if (vs && !prev_vs) frame_m = frame_m + 8'd1;
    prev_vs = vs;
    fq.push_back('{cyc + 1, frame_m});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_rgb", {o_red, o_green, o_blue}, 12'h000);
    check("reset_sync", {o_hsync, o_vsync}, 2'b00);
    check("reset_frame", o_frame, 8'h00);
    sb.delete();
    fq.delete();
    pal_m = PAL_DEF;
    frame_m = 8'h00;
    prev_vs = 1'b0;
    i_pal_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_rgb", {o_red, o_green, o_blue}, 12'h000);
    reset = 1'b0;
    // First edge after release shows the cleared S1 stage.
    sb.push_back('{cyc + 1, 12'h000, 1'b0, 1'b0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    i_mode = 2'd0; i_color = 4'd2; i_display_on = 1'b1;
    #2;
    do_reset();

    // Steady colour 2 after release
    for (int i = 0; i < 6; i++) pix(2'd0, 4'd2, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0);

    // Display window closes mid-run; random hsync pattern
    for (int i = 0; i < 12; i++)
      pix(2'd0, 4'd1, 10'(i), 10'd0, (i < 5), 1'($urandom_range(0, 1)), 1'b0);

    // Palette write while colour 5 streams, then reset restores default
    for (int i = 0; i < 3; i++) pix(2'd0, 4'd5, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    pix(2'd0, 4'd5, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 12'hABC);
    for (int i = 0; i < 3; i++) pix(2'd0, 4'd5, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) pix(2'd0, 4'd5, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0);

    // Write landing as the window closes
    pix(2'd0, 4'd3, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 12'h123);
    for (int i = 0; i < 3; i++) pix(2'd0, 4'd3, 10'd0, 10'd0, (i > 0), 1'b0, 1'b0);

    // Colour bars across the full line
    for (int h = 0; h < 1024; h++) pix(2'd1, 4'd0, 10'(h), 10'd7, 1'b1, (h < 8), 1'b0);

    // Raster gradient, including positions past 15
    for (int v = 0; v < 40; v += 3) pix(2'd2, 4'd0, 10'd100, 10'(v * 7), 1'b1, 1'b0, 1'b0);

    // Frame counter: 300 pulses wrap once to 44, a long pulse counts once
    do_reset();
    for (int p = 0; p < 300; p++) begin
      pix(2'd0, 4'd6, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
      pix(2'd0, 4'd6, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    end
    check("frame_300", o_frame, 8'd44);
    for (int i = 0; i < 10; i++) pix(2'd0, 4'd6, 10'd0, 10'd0, 1'b1, 1'b0, 1'b1);
    pix(2'd0, 4'd6, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    check("frame_held", o_frame, 8'd45);

    // Checkerboard with reset mid-line
    for (int h = 0; h < 20; h++) pix(2'd3, 4'd0, 10'(h), 10'd3, 1'b1, (h > 10), 1'b0);
    do_reset();
    for (int h = 0; h < 40; h++) pix(2'd3, 4'd0, 10'(h), 10'd0, 1'b1, 1'b0, 1'b0);
    for (int h = 0; h < 40; h++) pix(2'd3, 4'd0, 10'(h), 10'd16, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size() + fq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
